// File: rtl/rr_arb4_pkg.sv
// Shared constants for the 4-way round-robin arbiter: state encoding and
// the default hold limit, used by the RTL and its bench alike.
package rr_arb4_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int HOLD_MAX_DEF = 8;

  // Next search start after releasing requester idx (3 wraps to 0).
  function automatic logic [1:0] next_ptr(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin search: first set request at PTR, PTR+1, ...
// modulo 4.
module rr_pick4 (
  input  logic [3:0] i_req,
  input  logic [1:0] i_ptr,
  output logic       o_hit,
  output logic [1:0] o_win
);

  logic [1:0] w_cand;

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    o_hit  = |i_req;
    o_win  = i_ptr;
    w_cand = i_ptr;
    for (int k = 3; k >= 0; k--) begin
      w_cand = i_ptr + 2'(k);
      if (i_req[w_cand]) o_win = w_cand;
    end
  end

endmodule

// File: rtl/rr_arb4.sv
// 4-requester round-robin arbiter with a bounded hold time; grants are
// registered, and a forced release at the hold limit pulses o_timeout.
module rr_arb4
  import rr_arb4_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_req,
  input  logic       i_done,
  output logic       o_en,
  output logic [1:0] o_idx,
  output logic       o_timeout
);

  localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);

  state_t        r_state;
  logic [1:0]    r_idx;
  logic [1:0]    r_ptr;
  logic [CW-1:0] r_cnt;
  logic          r_timeout;

  logic       w_hit;
  logic [1:0] w_win;
  logic       w_norm;
  logic       w_lim;
  logic       w_rel;

  rr_pick4 u_pick (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_hit (w_hit),
    .o_win (w_win)
  );

  // A normal release (done or dropped request) masks the timeout even when
  // it lands on the limit cycle.
  assign w_norm = i_done | ~i_req[r_idx];
  assign w_lim  = (r_cnt == CNT_LAST);
  assign w_rel  = w_norm | w_lim;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_idx     <= 2'b00;
      r_ptr     <= 2'b00;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_hit) begin
            r_state <= GRANT;
            r_idx   <= w_win;
            r_cnt   <= '0;
          end
        end
        GRANT: begin
          if (w_rel) begin
            r_state   <= IDLE;
            r_ptr     <= next_ptr(r_idx);
            r_cnt     <= '0;
            r_timeout <= w_lim & ~w_norm;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_en      = (r_state == GRANT);
  assign o_idx     = r_idx;
  assign o_timeout = r_timeout;

endmodule

// File: tb/tb_rr_arb4.sv
// Bench for rr_arb4: a cycle-level arbitration model checked every cycle,
// plus directed vectors with literal expectations.
module tb_rr_arb4;
  import rr_arb4_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic       en;
  logic [1:0] idx;
  logic       tmo;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 0;

  rr_arb4 #(.HOLD_MAX(HOLD_MAX_DEF)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_req     (req),
    .i_done    (done),
    .o_en      (en),
    .o_idx     (idx),
    .o_timeout (tmo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: who holds the grant, how many cycles it has held, and where the
  // next search begins.
  bit m_en, m_to;
  int m_idx, m_ptr, m_age;

  always @(posedge clk) begin
    if (rst) begin
      m_en = 0; m_to = 0; m_idx = 0; m_ptr = 0; m_age = 0;
    end else if (m_en) begin
      m_to = 0;
      if (done || !req[m_idx] || m_age == HOLD_MAX_DEF - 1) begin
        m_to  = !done && req[m_idx];
        m_en  = 0;
        m_ptr = (m_idx + 1) % 4;
        m_age = 0;
      end else begin
        m_age++;
      end
    end else begin
      m_to = 0;
      for (int k = 0; k < 4; k++) begin
        if (req[(m_ptr + k) % 4]) begin
          m_idx = (m_ptr + k) % 4;
          m_en  = 1;
          m_age = 0;
          break;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_en", int'(en), int'(m_en));
      check("model_idx", int'(idx), m_idx);
      check("model_timeout", int'(tmo), int'(m_to));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] dec24(input logic e, input logic [1:0] i);
    logic [3:0] one;
    one = 4'b0001;
    return e ? (one << i) : 4'b0000;
  endfunction

  localparam int SEQ[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b1; req = 4'b0000; done = 1'b0;
    step(2);
    check("reset_en", int'(en), 0);
    check("reset_idx", int'(idx), 0);
    check("reset_timeout", int'(tmo), 0);
    rst = 1'b0;
    chk_on = 1;

    // Idle with no requests
    for (int c = 0; c < 5; c++) begin
      step(1);
      check("idle_en", int'(en), 0);
      check("idle_idx", int'(idx), 0);
      check("idle_timeout", int'(tmo), 0);
    end

    // Single requester 2, done on the third grant cycle
    req = 4'b0100;
    step(1);
    check("r2_en", int'(en), 1);
    check("r2_idx", int'(idx), 2);
    step(2);
    done = 1'b1;
    step(1);
    check("r2_rel_en", int'(en), 0);
    check("r2_rel_idx_hold", int'(idx), 2);
    check("model_ptr_after_r2", m_ptr, 3);
    done = 1'b0;
    req = 4'b1001;
    step(1);
    check("ptr3_pick", int'(idx), 3);
    done = 1'b1;
    step(1);
    check("ptr3_rel_en", int'(en), 0);
    done = 1'b0;

    // All requesting, done on each grant's second cycle
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      step(1);
      check("rr_en", int'(en), 1);
      check("rr_idx", int'(idx), SEQ[g]);
      step(1);
      done = 1'b1;
      step(1);
      check("rr_gap", int'(en), 0);
      done = 1'b0;
    end

    // Dropped request releases without timeout
    req = 4'b0001;
    step(1);
    check("drop_idx", int'(idx), 0);
    req = 4'b0000;
    step(1);
    check("drop_en", int'(en), 0);
    check("drop_timeout", int'(tmo), 0);

    // Requester 1 alone, held past the limit
    req = 4'b0010;
    step(1);
    check("hold_first", int'(en), 1);
    for (int c = 1; c < HOLD_MAX_DEF; c++) begin
      step(1);
      check("hold_en", int'(en), 1);
      check("hold_no_tmo", int'(tmo), 0);
    end
    step(1);
    check("limit_en", int'(en), 0);
    check("limit_timeout", int'(tmo), 1);
    step(1);
    check("regrant_en", int'(en), 1);
    check("regrant_idx", int'(idx), 1);
    check("pulse_cleared", int'(tmo), 0);

    // Done on the limit cycle counts as normal
    step(HOLD_MAX_DEF - 1);
    check("lim_done_pre", int'(en), 1);
    done = 1'b1;
    step(1);
    check("lim_done_en", int'(en), 0);
    check("lim_done_tmo", int'(tmo), 0);
    done = 1'b0;

    // Reset mid-grant on requester 3
    req = 4'b1000;
    step(1);
    check("pre_rst_idx", int'(idx), 3);
    step(1);
    rst = 1'b1;
    step(1);
    check("rst_en", int'(en), 0);
    check("rst_idx", int'(idx), 0);
    check("rst_tmo", int'(tmo), 0);
    req = 4'b1111; done = 1'b1;
    step(1);
    check("rst_ignore_en", int'(en), 0);
    rst = 1'b0; done = 1'b0;
    step(1);
    check("post_rst_idx", int'(idx), 0);
    check("dec24_onehot", int'(dec24(en, idx)), 1);
    step(1);
    check("dec24_onehot2", int'(dec24(en, idx)), 1);
    req = 4'b0000;
    step(3);

    chk_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_arb4.md
RR_ARB4 -- requirements
Module: rr_arb4

Interface
REQ-001 The block SHALL have a single clock, CLK; reset SHALL be RST, synchronous and active-high.
REQ-002 Parameter HOLD_MAX, default 8: maximum number of cycles a grant is held before forced release (legal range 2..256).
REQ-003 CLK  input  1  system clock; all state updates occur on the rising edge.
REQ-004 RST  input  1  synchronous active-high reset.
REQ-005 REQ  input  4  request lines; REQ[i]=1 means requester i wants the grant.
REQ-006 DONE  input  1  the current grantee signals completion; sampled only while a grant is active.
REQ-007 EN  output  1  grant valid; connects directly to DEC24 EN.
REQ-008 IDX  output  2  index of the granted requester; connects directly to DEC24 IN.
REQ-009 TIMEOUT  output  1  one-cycle pulse when a grant is forcibly released at HOLD_MAX.

Function
REQ-010 The block SHALL implement two states: IDLE (EN=0) and GRANT (EN=1).
REQ-011 In IDLE with REQ=4'b0000, the block SHALL remain in IDLE with all outputs unchanged.
REQ-012 In IDLE with any REQ bit set, the block SHALL select the first set bit found searching PTR, PTR+1, ... modulo 4.
REQ-013 The selection SHALL be registered: a request sampled at edge k SHALL give EN=1 and IDX=winner after edge k (latency 1 cycle).
REQ-014 In GRANT, IDX SHALL remain stable, and the hold counter SHALL increment by 1 every cycle, starting at 0.
REQ-015 The grant SHALL be released when any one of the following holds: DONE=1; REQ[IDX]=0; or the hold counter equals HOLD_MAX-1.
REQ-016 On release, after the edge the block SHALL be in IDLE with EN=0, PTR=IDX+1 mod 4 (3 wraps to 0), and the hold counter cleared.
REQ-017 IDX SHALL hold its last value while in IDLE.
REQ-018 TIMEOUT SHALL be 1 for exactly the one cycle following a release caused solely by the counter limit.
REQ-019 If DONE or a dropped REQ[IDX] coincides with the counter limit, the release SHALL count as normal and TIMEOUT SHALL remain 0.
REQ-020 Between consecutive grants, EN SHALL be low for exactly one cycle, even with continuous requests.
REQ-021 Changes to REQ bits other than REQ[IDX] during GRANT SHALL have no effect until the next IDLE cycle.
REQ-022 At most one grant SHALL be active at any time, and EN=1 SHALL never coexist with REQ[IDX]=0 for more than one cycle.
REQ-023 The hold counter width SHALL be clog2(HOLD_MAX), and the counter SHALL never wrap within a grant.

Reset
REQ-024 While RST=1 at an edge, the block SHALL set state=IDLE, EN=0, IDX=2'b00, TIMEOUT=0, PTR=0, and hold counter=0.
REQ-025 A reset asserted mid-grant SHALL drop EN after that edge, with no TIMEOUT pulse.
REQ-026 In the first cycle after RST deasserts, arbitration SHALL start from PTR=0.
REQ-027 REQ and DONE SHALL be ignored during reset.

Structure
REQ-028 The state encodings (IDLE=1'b0, GRANT=1'b1) and the HOLD_MAX default SHALL live in a shared constants file used by rr_arb4 and its testbench.
REQ-029 The round-robin search SHALL be a combinational sub-module, rr_pick4, with inputs REQ[3:0] and PTR[1:0] and outputs HIT and WIN[1:0].
REQ-030 All registers SHALL reside in rr_arb4, and no outputs SHALL be driven combinationally from REQ.

Verification
REQ-031 Reset then REQ=4'b0000 for 5 cycles -> EN=0, IDX=0, TIMEOUT=0 throughout.
REQ-032 REQ=4'b0100, then DONE=1 on the 3rd grant cycle -> EN=1, IDX=2 one cycle after REQ; EN=0 after DONE; next PTR=3.
REQ-033 REQ=4'b1111 held with DONE pulsed on each grant's 2nd cycle -> IDX sequence 0,1,2,3,0 with a one-cycle EN gap between grants.
REQ-034 REQ=4'b0010 held and DONE=0, HOLD_MAX=8 -> EN high for exactly 8 cycles, then a one-cycle TIMEOUT pulse, and the next grant goes to IDX=1 after the gap.
REQ-035 DONE=1 on the same cycle the counter reaches 7 -> release with TIMEOUT=0.
REQ-036 RST=1 mid-grant with IDX=3 -> EN=0, IDX=0 after the edge; the first grant after reset searches from 0; the DEC24 output follows as a one-hot code of IDX while EN=1.
